// File: rtl/ula_arbiter_if.sv
// Bundle of requester-side and response-side signals for the shared ALU arbiter.
// Latency: none (wires only).
// Backpressure: req_ready per requester; responses have no backpressure.
interface ula_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
);
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [2*N-1:0]    req_controle;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_zero;
  logic              rsp_overflow;
  logic [31:0]       op_count;

  // Requester side drives operations and observes grants and responses.
  modport master (
    output req_valid, req_a, req_b, req_controle,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, op_count
  );

  // Arbiter side consumes operations and produces grants and responses.
  modport slave (
    input  req_valid, req_a, req_b, req_controle,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, op_count
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU (add/sub/and/or + zero/overflow) among N requesters.
// Latency: grant in the request cycle, registered response one cycle later; one op per cycle.
// Backpressure: losers wait with req_valid held; responses are single-cycle pulses, never stalled.

module ula_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  controle,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);
  // Combinational ALU: result, signed overflow for add/sub, zero for every opcode.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (controle)
      2'b00: begin
        result   = a + b;
        overflow = (a[31] == b[31]) && (result[31] != a[31]);
      end
      2'b01: begin
        result   = a + ~b + 32'd1;
        overflow = (a[31] != b[31]) && (result[31] != a[31]);
      end
      2'b10:   result = a & b;
      default: result = a | b;
    endcase
    zero = (result == 32'd0);
  end
endmodule

module ula_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input logic          clk,
  input logic          reset_n,
  ula_arbiter_if.slave bus
);
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_result_q, rsp_result_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_overflow_q, rsp_overflow_d;
  logic [31:0]    op_count_q, op_count_d;

  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand_idx;
  logic [N-1:0]   ready;
  logic [31:0]    alu_a, alu_b;
  logic [1:0]     alu_ctl;
  logic [31:0]    alu_result;
  logic           alu_zero, alu_overflow;

  // First valid requester found scanning upward from the pointer, wrapping at N.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand_idx = IDW'((32'(ptr_q) + k) % N);
      if (!gnt_vld && bus.req_valid[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  // One-hot ready to the winner, suppressed while reset is asserted; ALU sees zeros when idle.
  always_comb begin
    ready   = '0;
    alu_a   = '0;
    alu_b   = '0;
    alu_ctl = '0;
    if (gnt_vld && reset_n) begin
      ready[gnt_idx] = 1'b1;
    end
    if (gnt_vld) begin
      alu_a   = bus.req_a[32*int'(gnt_idx) +: 32];
      alu_b   = bus.req_b[32*int'(gnt_idx) +: 32];
      alu_ctl = bus.req_controle[2*int'(gnt_idx) +: 2];
    end
  end

  ula_alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .controle (alu_ctl),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  // Next state: capture the ALU output and advance the pointer past the winner on a grant.
  always_comb begin
    ptr_d          = ptr_q;
    rsp_valid_d    = 1'b0;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_overflow_d = rsp_overflow_q;
    op_count_d     = op_count_q;
    if (gnt_vld) begin
      rsp_valid_d    = 1'b1;
      rsp_id_d       = gnt_idx;
      rsp_result_d   = alu_result;
      rsp_zero_d     = alu_zero;
      rsp_overflow_d = alu_overflow;
      ptr_d          = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDW'(1);
      op_count_d     = op_count_q + 32'd1;
    end
  end

  // State registers; asynchronous reset clears any pending response and the pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      op_count_q     <= '0;
    end else begin
      ptr_q          <= ptr_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_overflow_q <= rsp_overflow_d;
      op_count_q     <= op_count_d;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.op_count     = op_count_q;
endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Shares one 32-bit ALU (add, sub, AND, OR with zero and overflow flags) among `N` requesters. The arbiter picks one valid request per cycle in round-robin order, applies it to the ALU, and returns a registered result one cycle later, tagged with the winner's index. It sits between the requesters (datapath stages or test masters) and the single ALU instance, which it instantiates internally.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `IDW`, 2: requester index width, $clog2(N).

Ports (vectors indexed by requester i, slice i occupies bits [i*W +: W]):
- `clk`  in  1  clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset (already decided).
- `req_valid`  in  N  requester i has an operation pending.
- `req_a`  in  32*N  operand a of requester i.
- `req_b`  in  32*N  operand b of requester i.
- `req_controle`  in  2*N  opcode of requester i: 00 add, 01 sub (a-b), 10 AND, 11 OR.
- `req_ready`  out  N  one-hot or zero; requester i's operation is accepted this cycle.
- `rsp_valid`  out  1  response register holds a result this cycle.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_result`  out  32  ALU result.
- `rsp_zero`  out  1  result == 0.
- `rsp_overflow`  out  1  signed overflow; 0 for AND/OR.
- `op_count`  out  32  total accepted operations, wraps modulo 2^32.

## Operation
- State: round-robin pointer `ptr` (IDW bits), response register (valid, id, result, zero, overflow), `op_count`.
- Arbitration is combinational each cycle. The grant `g` is the first i with `req_valid[i]=1`, searching `ptr, ptr+1, … , N-1, 0, … , ptr-1`.
- `req_ready[g]=1`, all other bits 0. If no request is valid, `req_ready=0`.
- A handshake completes when `req_valid[i] & req_ready[i]`. The requester holds a, b and controle stable while `req_valid` is high. It drops `req_valid` in the next cycle if it has no further work.
- The ALU is fed with the granted slice. When there is no grant, ALU inputs are 0.
- ALU rules:
  - add: sum = a+b, overflow = (a31==b31) & (r31!=a31).
  - sub: sum = a+~b+1, overflow = (a31!=b31) & (r31!=a31).
  - AND, OR: bitwise, overflow = 0.
  - zero = (result==0) for every opcode.
  - All arithmetic is 32-bit with the carry out discarded.
- On a grant:
  - The response register loads {1, g, result, zero, overflow}.
  - `ptr` becomes (g+1) mod N.
  - `op_count` increments.
- With no grant: `rsp_valid` is 0 next cycle, the other response fields hold their last value, and `ptr` holds.
- Responses have no backpressure. `rsp_valid` is a one-cycle pulse per accepted operation, and requesters match on `rsp_id`.
- Fairness: a continuously requesting i is granted within N cycles.

## Timing
- Reset (asynchronous assert, synchronous release on the first `clk` edge after deassert):
  - `ptr=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_zero=0`, `rsp_overflow=0`, `op_count=0`.
  - `req_ready` is forced to 0 while `reset_n=0`.
- Latency:
  - `req_ready` is asserted in the same cycle as `req_valid` (cycle T).
  - The response is visible after the edge ending cycle T (cycle T+1).
- Throughput is one operation per cycle, sustained.
- Simultaneous requests: only one grant per cycle. Losers keep `req_valid` and are served in later cycles in pointer order.
- Reset mid-operation: any pending response is discarded, `rsp_valid` drops immediately, and the pointer returns to 0.
- Pointer wrap: a grant at i=N-1 sets `ptr=0`.
- `op_count` wraps from FFFFFFFF to 0.

## Test plan
- Reset then single request. Hold `reset_n=0` for 3 cycles: all outputs are 0. Then requester 2 issues add 00000005+00000003 → `req_ready=0100` in the same cycle; next cycle `rsp_valid=1`, `rsp_id=2`, result 00000008, zero=0, overflow=0; `op_count=1`.
- All four requesters valid continuously for 8 cycles (ptr=0) → grant order 0,1,2,3,0,1,2,3, one `rsp_valid` per cycle with matching `rsp_id`, `op_count=8`.
- Flags:
  - add 7FFFFFFF+00000001 → 80000000, overflow=1.
  - sub 80000000-00000001 → 7FFFFFFF, overflow=1.
  - sub 12345678-12345678 → 0, zero=1, overflow=0.
  - AND F0F0F0F0&0F0F0F0F → 0, zero=1, overflow=0.
  - OR 00FF0000|000000FF → 00FF00FF.
- Gap and fairness. Requester 1 issues a request after ptr=2; then requesters 0 and 3 issue simultaneously → 3 is granted before 0. With no request in a cycle, `rsp_valid` is 0 the following cycle and `ptr` is unchanged.
- Reset mid-stream. Assert `reset_n=0` asynchronously between edges while `rsp_valid=1` → `rsp_valid` and `req_ready` drop immediately, and `op_count=0`. After release, requester 3's pending request is granted first at ptr=0 order (0,1,2,3).
- Counter wrap. Force `op_count` to FFFFFFFF and issue one operation → `op_count=00000000`.
